// File: rtl/vga_line_buffer_if.sv
// ---------------------------------------------------------------------------
// vga_line_buffer_if
//   Row-fetch / fill bus between the VGA line buffer and the VRAM controller.
//
//   VGA_re    line buffer -> controller  one-cycle row-fetch request
//   VGA_y     line buffer -> controller  row being fetched (9 bits)
//   VGA_we    controller -> line buffer  fill-pixel strobe
//   VGA_x     controller -> line buffer  fill-pixel column (10 bits)
//   VGA_data  controller -> line buffer  fill pixel, RGB888
//
//   master : the VRAM controller side
//   slave  : the line buffer side
// ---------------------------------------------------------------------------
interface vga_line_buffer_if;
  logic        VGA_re;
  logic [8:0]  VGA_y;
  logic        VGA_we;
  logic [9:0]  VGA_x;
  logic [23:0] VGA_data;

  modport master (
    input  VGA_re,
    input  VGA_y,
    output VGA_we,
    output VGA_x,
    output VGA_data
  );

  modport slave (
    output VGA_re,
    output VGA_y,
    input  VGA_we,
    input  VGA_x,
    input  VGA_data
  );
endinterface

// File: rtl/vga_line_buffer.sv
// ---------------------------------------------------------------------------
// vga_line_buffer
//   Double-buffered scanline store between a VRAM controller and the display
//   timing. The display side reads the front bank while the fill side loads
//   the next row into the back bank; a line_start pulse swaps the banks once
//   the back bank is complete, otherwise a sticky underrun flag is raised.
//
// Parameters
//   SCREEN_W  active pixels per line, also the depth of each bank
//   SCREEN_H  active lines per frame
//
// Ports
//   clk          system clock, posedge
//   rst_n        asynchronous active-low reset, deassertion synchronised
//   vram         fill bus (slave modport of vga_line_buffer_if)
//   line_start   one-cycle pulse at the start of every display line
//   disp_y       display line index, valid with line_start
//   disp_x       display pixel column
//   disp_active  display is in the active region
//   rgb_out      displayed pixel, one cycle after disp_x
//   underrun     sticky: a line_start arrived before the back bank was full
// ---------------------------------------------------------------------------
`ifndef SCREEN_W
`define SCREEN_W 320
`endif
`ifndef SCREEN_H
`define SCREEN_H 240
`endif

module vga_line_buffer #(
  parameter int SCREEN_W = `SCREEN_W,
  parameter int SCREEN_H = `SCREEN_H
) (
  input  logic                    clk,
  input  logic                    rst_n,
  vga_line_buffer_if.slave        vram,
  input  logic                    line_start,
  input  logic [9:0]              disp_y,
  input  logic [9:0]              disp_x,
  input  logic                    disp_active,
  output logic [23:0]             rgb_out,
  output logic                    underrun
);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_REQ,
    ST_FILL,
    ST_DONE
  } state_t;

  localparam int         AW     = (SCREEN_W > 1) ? $clog2(SCREEN_W) : 1;
  localparam logic [9:0] W_LIM  = 10'(SCREEN_W);
  localparam logic [9:0] W_LAST = 10'(SCREEN_W - 1);
  localparam logic [9:0] H_LAST = 10'(SCREEN_H - 1);

  // Reset deassertion synchroniser: the control state is held in its reset
  // value for the first edge after rst_n rises, so the first fetch request
  // appears on the second edge.
  logic rst_sync_reg;

  state_t     state_reg,    state_next;
  logic       bank_sel_reg, bank_sel_next;
  logic [8:0] row_reg,      row_next;
  logic       underrun_reg, underrun_next;

  logic       fill_wr;
  logic       fill_last;
  logic       rd_in_range;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;

  logic       rd_valid_reg;
  logic       rd_sel_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_reg <= 1'b0;
    end else begin
      rst_sync_reg <= 1'b1;
    end
  end

  // Only in-range writes during FILL reach the back bank; anything else on
  // the fill bus is dropped without touching state.
  assign fill_wr     = vram.VGA_we && (state_reg == ST_FILL) && (vram.VGA_x < W_LIM);
  assign fill_last   = fill_wr && (vram.VGA_x == W_LAST);
  assign wr_addr     = vram.VGA_x[AW-1:0];
  assign rd_in_range = disp_active && (disp_x < W_LIM);
  assign rd_addr     = rd_in_range ? disp_x[AW-1:0] : '0;

  // -------------------------------------------------------------------------
  // Fill FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_INIT;
      bank_sel_reg <= 1'b0;
      row_reg      <= 9'd0;
      underrun_reg <= 1'b0;
    end else if (!rst_sync_reg) begin
      state_reg    <= ST_INIT;
      bank_sel_reg <= 1'b0;
      row_reg      <= 9'd0;
      underrun_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      bank_sel_reg <= bank_sel_next;
      row_reg      <= row_next;
      underrun_reg <= underrun_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    bank_sel_next = bank_sel_reg;
    row_next      = row_reg;
    underrun_next = underrun_reg;

    // A line_start that finds the back bank incomplete (including one that
    // coincides with the final write) is an underrun; the fill carries on.
    if (line_start && (state_reg != ST_DONE)) begin
      underrun_next = 1'b1;
    end

    case (state_reg)
      ST_INIT: state_next = ST_REQ;
      ST_REQ:  state_next = ST_FILL;
      ST_FILL: begin
        if (fill_last) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (line_start) begin
          state_next    = ST_REQ;
          bank_sel_next = ~bank_sel_reg;
          // Prefetch the row that will be displayed next; the last active
          // line and any blanking line wrap to row 0.
          if (disp_y >= H_LAST) begin
            row_next = 9'd0;
          end else begin
            row_next = 9'(disp_y + 10'd1);
          end
        end
      end
      default: state_next = ST_INIT;
    endcase
  end

  assign vram.VGA_re = (state_reg == ST_REQ);
  assign vram.VGA_y  = row_reg;
  assign underrun    = underrun_reg;

  // -------------------------------------------------------------------------
  // Line banks. Bank gi is the front bank when bank_sel == gi; writes only
  // ever target the other one, so a bank is never read and written at once.
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      localparam logic BANK_ID = 1'(gi);
      logic [23:0] mem [SCREEN_W];
      logic [23:0] rd_q;

      always_ff @(posedge clk) begin
        if (fill_wr && (bank_sel_reg != BANK_ID)) begin
          mem[wr_addr] <= vram.VGA_data;
        end
        rd_q <= mem[rd_addr];
      end
    end
  endgenerate

  // Bank select and validity are captured alongside the read, so a swap on
  // the line_start edge still returns that cycle's pixel from the old front.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_reg <= 1'b0;
      rd_sel_reg   <= 1'b0;
    end else begin
      rd_valid_reg <= rd_in_range;
      rd_sel_reg   <= bank_sel_reg;
    end
  end

  assign rgb_out = !rd_valid_reg ? 24'd0 :
                   (rd_sel_reg ? g_bank[1].rd_q : g_bank[0].rd_q);

endmodule

// File: tb/tb_vga_line_buffer.sv
// ---------------------------------------------------------------------------
// tb_vga_line_buffer
//   Directed bench for vga_line_buffer with a line-level reference model:
//   two banks of remembered pixels, which bank is on screen, whether the
//   back row is complete, and when a fetch request is due.
// ---------------------------------------------------------------------------
module tb_vga_line_buffer;
  localparam int W = 320;
  localparam int H = 240;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        line_start;
  logic [9:0]  disp_y;
  logic [9:0]  disp_x;
  logic        disp_active;
  logic [23:0] rgb_out;
  logic        underrun;

  int total = 0;
  int bad   = 0;

  vga_line_buffer_if vif ();

  vga_line_buffer #(.SCREEN_W(W), .SCREEN_H(H)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .vram        (vif),
    .line_start  (line_start),
    .disp_y      (disp_y),
    .disp_x      (disp_x),
    .disp_active (disp_active),
    .rgb_out     (rgb_out),
    .underrun    (underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] pix(input logic [7:0] tag, input int x);
    logic [7:0] b;
    b = x[7:0];
    if (tag == 8'd0) return {b, b, b};
    return {tag, b, ~b};
  endfunction

  // -------------------------------------------------------------------------
  // Reference model
  // -------------------------------------------------------------------------
  logic [23:0] mb [2][W];
  bit          mk [2][W];
  int          since;        // edges seen since reset release, saturating at 2
  bit          front;        // bank on screen
  bit          fetching;     // a row fetch is outstanding
  bit          full;         // back bank holds a complete row
  bit          m_re;
  logic [8:0]  m_y;
  bit          m_under;
  logic [23:0] m_rgb;
  bit          m_rgb_known;
  int          prev_since;
  bit          re_now, full_before, can_write;

  initial begin
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < W; i++) mk[b][i] = 1'b0;
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      since = 0; front = 0; fetching = 0; full = 0;
      m_re = 0; m_y = 9'd0; m_under = 0; m_rgb = 24'd0; m_rgb_known = 1;
    end else begin
      re_now      = m_re;
      full_before = full;
      can_write   = fetching && !re_now && !full_before;
      prev_since  = since;
      if (since < 2) since++;

      // Display read always sees the bank on screen before this edge.
      if (disp_active && disp_x < W) begin
        m_rgb       = mb[front][disp_x];
        m_rgb_known = mk[front][disp_x];
      end else begin
        m_rgb       = 24'd0;
        m_rgb_known = 1;
      end

      m_re = 0;
      if (prev_since == 1) begin
        m_re = 1; m_y = 9'd0; fetching = 1; full = 0;
        if (line_start) m_under = 1;
      end else if (prev_since == 2) begin
        if (can_write && vif.VGA_we && vif.VGA_x < W) begin
          mb[!front][vif.VGA_x] = vif.VGA_data;
          mk[!front][vif.VGA_x] = 1'b1;
          if (vif.VGA_x == W - 1) begin
            full = 1; fetching = 0;
          end
        end
        if (line_start) begin
          if (full_before) begin
            front    = !front;
            m_y      = (disp_y >= H - 1) ? 9'd0 : 9'(disp_y + 10'd1);
            m_re     = 1;
            fetching = 1;
            full     = 0;
          end else begin
            m_under = 1;
          end
        end
      end

      #1;
      check("cyc_VGA_re", vif.VGA_re, m_re);
      check("cyc_VGA_y", vif.VGA_y, m_y);
      check("cyc_underrun", underrun, m_under);
      if (m_rgb_known) check("cyc_rgb_out", rgb_out, m_rgb);
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus helpers
  // -------------------------------------------------------------------------
  task automatic fill_range(input int lo, input int hi, input logic [7:0] tag);
    for (int x = lo; x <= hi; x++) begin
      @(negedge clk);
      vif.VGA_we   = 1'b1;
      vif.VGA_x    = 10'(x);
      vif.VGA_data = pix(tag, x);
    end
  endtask

  task automatic we_off();
    @(negedge clk);
    vif.VGA_we = 1'b0;
  endtask

  // Line start with the display reading column 3 in the same cycle.
  task automatic pulse_ls(input logic [9:0] y);
    @(negedge clk);
    line_start  = 1'b1;
    disp_y      = y;
    disp_active = 1'b1;
    disp_x      = 10'd3;
    @(negedge clk);
    line_start  = 1'b0;
  endtask

  // Sweep one display line; with pin set, a few row-0 pixels are checked
  // against hand-computed values.
  task automatic sweep(input bit pin);
    for (int x = 0; x <= W; x++) begin
      @(negedge clk);
      if (pin && x > 0) begin
        case (x - 1)
          0:   check("pin_rgb_x0",   rgb_out, 24'h000000);
          5:   check("pin_rgb_x5",   rgb_out, 24'h050505);
          7:   check("pin_rgb_x7",   rgb_out, 24'h070707);
          255: check("pin_rgb_x255", rgb_out, 24'hffffff);
          319: check("pin_rgb_x319", rgb_out, 24'h3f3f3f);
          default: ;
        endcase
      end
      if (x < W) begin
        disp_active = 1'b1;
        disp_x      = 10'(x);
      end else begin
        disp_active = 1'b0;
        disp_x      = 10'd0;
      end
    end
  endtask

  initial begin
    #1000000;
    bad++;
    $display("FAIL watchdog: simulation still running at time limit");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // -------------------------------------------------------------------------
  // Directed sequence
  // -------------------------------------------------------------------------
  initial begin
    rst_n = 1'b0; line_start = 1'b0; disp_y = '0; disp_x = '0; disp_active = 1'b0;
    vif.VGA_we = 1'b0; vif.VGA_x = '0; vif.VGA_data = '0;

    repeat (3) @(negedge clk);
    check("rst_VGA_re", vif.VGA_re, 1'b0);
    check("rst_VGA_y", vif.VGA_y, 9'd0);
    check("rst_rgb_out", rgb_out, 24'd0);
    check("rst_underrun", underrun, 1'b0);

    rst_n = 1'b1;
    @(negedge clk); check("rel_re_edge1", vif.VGA_re, 1'b0);
    @(negedge clk); check("rel_re_edge2", vif.VGA_re, 1'b1);
    check("first_row", vif.VGA_y, 9'd0);
    @(negedge clk); check("re_one_cycle", vif.VGA_re, 1'b0);

    // Row 0 into the back bank, then a stray write while complete.
    fill_range(0, W - 1, 8'd0);
    we_off();
    @(negedge clk);
    vif.VGA_we = 1'b1; vif.VGA_x = 10'd7; vif.VGA_data = 24'hdeadbe;
    @(negedge clk);
    vif.VGA_we = 1'b0;
    check("done_stray_no_req", vif.VGA_re, 1'b0);

    // Swap to row 0, display it while row 1 fills (with a stray x=320 write).
    pulse_ls(10'd0);
    check("swap0_re", vif.VGA_re, 1'b1);
    check("swap0_y", vif.VGA_y, 9'd1);
    fork
      sweep(1'b1);
      begin
        fill_range(0, 199, 8'd1);
        @(negedge clk);
        vif.VGA_x = 10'd320; vif.VGA_data = 24'h123456;
        fill_range(200, W - 1, 8'd1);
        we_off();
      end
    join

    // Last active line wraps; the read in the line_start cycle uses the old front.
    pulse_ls(10'd239);
    check("wrap239_y", vif.VGA_y, 9'd0);
    check("old_front_read", rgb_out, 24'h030303);
    @(negedge clk);
    check("new_front_read", rgb_out, 24'h0103fc);
    fill_range(0, W - 1, 8'd2);
    we_off();

    pulse_ls(10'd500);
    check("blank500_y", vif.VGA_y, 9'd0);
    fill_range(0, W - 1, 8'd3);
    we_off();

    pulse_ls(10'd100);
    check("row101_y", vif.VGA_y, 9'd101);
    check("pre_underrun", underrun, 1'b0);

    // Underrun during fill at x=100; the front bank must stay on row tag 3.
    fork
      sweep(1'b0);
      begin
        fill_range(0, 99, 8'd4);
        @(negedge clk);
        vif.VGA_x = 10'd100; vif.VGA_data = pix(8'd4, 100);
        line_start = 1'b1; disp_y = 10'd5;
        @(negedge clk);
        line_start = 1'b0;
        check("underrun_set", underrun, 1'b1);
        check("underrun_no_req", vif.VGA_re, 1'b0);
        fill_range(101, W - 1, 8'd4);
        we_off();
      end
    join
    sweep(1'b0);

    pulse_ls(10'd5);
    check("after_underrun_swap", vif.VGA_re, 1'b1);
    check("after_underrun_y", vif.VGA_y, 9'd6);

    // line_start coinciding with the final write does not swap.
    fill_range(0, W - 2, 8'd5);
    @(negedge clk);
    vif.VGA_x = 10'd319; vif.VGA_data = pix(8'd5, 319);
    line_start = 1'b1; disp_y = 10'd7;
    @(negedge clk);
    line_start = 1'b0; vif.VGA_we = 1'b0;
    check("final_write_no_swap", vif.VGA_re, 1'b0);
    check("final_write_y_held", vif.VGA_y, 9'd6);

    pulse_ls(10'd20);
    check("swap20_re", vif.VGA_re, 1'b1);
    check("swap20_y", vif.VGA_y, 9'd21);
    @(negedge clk);
    check("swap20_front", rgb_out, 24'h0503fc);

    // Reset in the middle of a fill at x=150.
    fill_range(0, 149, 8'd6);
    @(negedge clk);
    vif.VGA_x = 10'd150; vif.VGA_data = pix(8'd6, 150);
    check("pre_rst_y", vif.VGA_y, 9'd21);
    check("pre_rst_rgb", rgb_out, 24'h0503fc);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_re", vif.VGA_re, 1'b0);
    check("async_rst_y", vif.VGA_y, 9'd0);
    check("async_rst_rgb", rgb_out, 24'd0);
    check("async_rst_underrun", underrun, 1'b0);
    vif.VGA_we = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); check("rel2_re_edge1", vif.VGA_re, 1'b0);
    @(negedge clk); check("rel2_re_edge2", vif.VGA_re, 1'b1);
    check("rel2_row", vif.VGA_y, 9'd0);

    fill_range(0, W - 1, 8'd0);
    we_off();
    pulse_ls(10'd0);
    check("rel2_swap_y", vif.VGA_y, 9'd1);
    @(negedge clk);
    check("rel2_front", rgb_out, 24'h030303);
    sweep(1'b1);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
